// File: rtl/dmem_pkg.sv
// Shared types and helpers for the Y86-64 data memory: size encoding, FSM states, byte-mask math.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_QUAD = 2'd3;

    // Widest word the mask helper supports (DATA_W up to 512)
    localparam int MAX_BYTES = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmemState_e;

    function automatic int sizeBytes(input logic [1:0] size, input int bytesPerWord);
        int n;
        case (size)
            SIZE_BYTE: n = 1;
            SIZE_HALF: n = 2;
            SIZE_WORD: n = 4;
            SIZE_QUAD: n = 8;
            default:   n = 1;
        endcase
        return (n > bytesPerWord) ? bytesPerWord : n;
    endfunction

    // Bytes off..off+n-1 set; anything past MAX_BYTES simply falls off
    function automatic logic [MAX_BYTES-1:0] byteEnable(input int off, input int n);
        logic [MAX_BYTES-1:0] m;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i >= off) && (i < off + n);
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage with one write lane per byte and an asynchronous read port.
module dmem_word_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int WORD_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic [WORD_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   byteEn,
    input  logic [DATA_W-1:0]     wrData,
    output logic [DATA_W-1:0]     rdData
);
    localparam int BYTES = DATA_W / 8;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : gLane
            logic [7:0] lane [DEPTH];

            always_ff @(posedge clock) begin
                if (byteEn[gi]) begin
                    lane[addr] <= wrData[gi*8 +: 8];
                end
            end

            assign rdData[gi*8 +: 8] = lane[addr];
        end
    endgenerate

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-granular Y86-64 data memory with valid/ready requests and a registered response.
// Define DMEM_MISALIGN_SPLIT_EN to run word-crossing accesses as two beats; otherwise they fault.
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 64
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqWrite,
    input  logic [ADDR_W-1:0]   reqAddr,
    input  logic [1:0]          reqSize,
    input  logic [DATA_W-1:0]   reqWdata,
    output logic                rspValid,
    output logic [DATA_W-1:0]   rspRdata,
    output logic                rspError
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int WORD_W = $clog2(DEPTH);
    localparam int CNT_W  = OFF_W + 2;
    localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(BYTES);

    logic [OFF_W-1:0]  reqOff;
    logic [WORD_W-1:0] reqWord;
    logic [CNT_W-1:0]  reqN, offEnd, lowCount;
    logic [ADDR_W:0]   endAddr;
    logic              rangeFault, crossing, fault, accept;
    logic [WORD_W-1:0] memAddr;
    logic [BYTES-1:0]  memBe;
    logic [DATA_W-1:0] memWdata, memRdata, loadData;

`ifdef DMEM_MISALIGN_SPLIT_EN
    dmemState_e        stateReg;
    logic [WORD_W-1:0] splitWordReg;
    logic [BYTES-1:0]  splitKeepReg;
    logic [DATA_W-1:0] splitWdataReg, splitLowReg, splitLoad;
    logic [CNT_W-1:0]  splitShiftReg;
    logic              splitWriteReg;
`endif

    function automatic logic [DATA_W-1:0] expandBytes(input logic [BYTES-1:0] be);
        logic [DATA_W-1:0] bits;
        for (int i = 0; i < BYTES; i++) begin
            bits[i*8 +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

    always_comb begin
        reqOff     = reqAddr[OFF_W-1:0];
        reqWord    = reqAddr[OFF_W +: WORD_W];
        reqN       = CNT_W'(sizeBytes(reqSize, BYTES));
        offEnd     = CNT_W'(reqOff) + reqN;
        lowCount   = CNT_W'(BYTES) - CNT_W'(reqOff);
        crossing   = offEnd > CNT_W'(BYTES);
        // One extra bit so addresses near the top of the space cannot wrap into range
        endAddr    = {1'b0, reqAddr} + (ADDR_W+1)'(reqN);
        rangeFault = endAddr > CAPACITY;
`ifdef DMEM_MISALIGN_SPLIT_EN
        fault      = rangeFault;
`else
        fault      = rangeFault || crossing;
`endif
        accept     = reqValid && reqReady;
        loadData   = (memRdata >> {reqOff, 3'b000})
                   & expandBytes(BYTES'(byteEnable(0, int'(reqN))));
    end

    always_comb begin
        memAddr  = reqWord;
        memWdata = reqWdata << {reqOff, 3'b000};
        memBe    = '0;
        // A crossing store's first beat is the same mask clipped at the word edge
        if (accept && reqWrite && !fault) begin
            memBe = BYTES'(byteEnable(int'(reqOff), int'(reqN)));
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (stateReg == SPLIT) begin
            memAddr  = splitWordReg;
            memWdata = splitWdataReg;
            memBe    = splitWriteReg ? splitKeepReg : '0;
        end
`endif
        if (!resetN) begin
            memBe = '0;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign splitLoad = ((memRdata & expandBytes(splitKeepReg)) << {splitShiftReg, 3'b000})
                     | splitLowReg;
`endif

    dmem_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) uArray (
        .clock  (clock),
        .addr   (memAddr),
        .byteEn (memBe),
        .wrData (memWdata),
        .rdData (memRdata)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            reqReady <= 1'b0;
            rspValid <= 1'b0;
            rspRdata <= '0;
            rspError <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            stateReg <= IDLE;
`endif
        end else begin
            reqReady <= 1'b1;
            rspValid <= 1'b0;
            rspRdata <= '0;
            rspError <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (stateReg == SPLIT) begin
                stateReg <= IDLE;
                rspValid <= 1'b1;
                rspRdata <= splitWriteReg ? '0 : splitLoad;
            end else
`endif
            if (accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (crossing && !fault) begin
                    stateReg      <= SPLIT;
                    reqReady      <= 1'b0;
                    splitWordReg  <= reqWord + WORD_W'(1);
                    splitKeepReg  <= BYTES'(byteEnable(0, int'(offEnd) - BYTES));
                    splitWdataReg <= reqWdata >> {lowCount, 3'b000};
                    splitLowReg   <= memRdata >> {reqOff, 3'b000};
                    splitShiftReg <= lowCount;
                    splitWriteReg <= reqWrite;
                end else
`endif
                begin
                    rspValid <= 1'b1;
                    rspError <= fault;
                    rspRdata <= (reqWrite || fault) ? '0 : loadData;
                end
            end
        end
    end

endmodule

// File: doc/data_memory_pipelined.md
# data_memory_pipelined

Parametrised single-port data memory for the Y86-64 datapath, successor to the fixed 64-bit memRead/memWrite array. It supports byte-granular loads and stores of 1, 2, 4 or 8 bytes in little-endian order, and uses a valid/ready request handshake with a registered response. It also reports range faults, which the execute/memory stage maps to status ADR, and can split word-crossing accesses into two beats. It sits between the memory stage and on-chip storage.

## Interface
- DATA_W, 64: word width in bits; multiple of 8, power of two; BYTES = DATA_W/8
- DEPTH, 1024: number of words; power of two; capacity = DEPTH*BYTES bytes
- ADDR_W, 64: byte-address width
- clock  in  1  rising-edge clock
- resetN  in  1  reset; one clock; reset is synchronous and active-low
- reqValid  in  1  request present
- reqReady  out  1  request accepted at an edge where reqValid && reqReady
- reqWrite  in  1  1 = store, 0 = load
- reqAddr  in  ADDR_W  byte address
- reqSize  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B (capped at BYTES)
- reqWdata  in  DATA_W  store data, LSB-aligned
- rspValid  out  1  one-cycle pulse: response available
- rspRdata  out  DATA_W  load data, zero-extended; 0 for stores and faults
- rspError  out  1  access faulted; qualified by rspValid

## Operation
- Decode: n = 1<<reqSize; word = reqAddr / BYTES; off = reqAddr % BYTES.
- Range fault: reqAddr + n > DEPTH*BYTES, computed at ADDR_W+1 bits with no wrap. On a range fault: no write, rspError=1, rspRdata=0.
- Aligned-within-word (off + n <= BYTES):
  - Single beat.
  - Store writes bytes off..off+n-1 of word via byte enables.
  - Load returns those bytes shifted to bit 0.
- Crossing (off + n > BYTES): handled per Configuration.
- FSM:
  - IDLE: reqReady=1.
  - IDLE → SPLIT on acceptance of an in-range crossing access.
  - SPLIT: reqReady=0; completes the second beat on the next edge, then → IDLE.
  - All other accepted requests stay in IDLE.
- No response backpressure: the consumer always takes rspValid.
- Memory contents are not cleared by reset.

## Timing
- Request accepted at edge N:
  - Single beat: rspValid high in the cycle after edge N+1... precisely, rspValid is registered at edge N and high during cycle N+1.
  - Split: rspValid registered at edge N+1.
- Stores commit at the accepting edge; split stores commit the second beat at edge N+1.
- A load accepted the cycle after a store to the same bytes returns the new data.
- Back-to-back single-beat requests sustain one request per cycle.
- Reset values, held while resetN=0:
  - rspValid=0, rspRdata=0, rspError=0
  - state=IDLE, reqReady=0 (reqReady=1 from the first cycle after release)
- Reset during SPLIT:
  - Second beat abandoned; the first-beat write stays committed.
  - No response is produced.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined:
  - Crossing accesses run as two beats.
  - Beat 1 covers word bytes off..BYTES-1; beat 2 covers word+1 bytes 0..off+n-BYTES-1.
  - Load data is concatenated {high, low}.
- Undefined:
  - Crossing accesses fault in a single beat: rspError=1, no write, rspRdata=0.
  - SPLIT state and its holding registers are removed.

## Structure
- Package dmem_pkg:
  - reqSize encoding constants
  - state enum {IDLE, SPLIT}
  - sizeBytes() function
  - byteEnable(off, n) mask function
- Sub-module dmem_word_array:
  - DEPTH×DATA_W storage
  - Per-byte write enables
  - Combinational read
- Top level holds the FSM, split holding registers (word+1, remaining mask, shifted wdata, low read bytes) and response registers.

## Test plan
All scenarios use DATA_W=64, DEPTH=16 (128 bytes).
- Reset: hold resetN=0 for 2 cycles → rspValid=0, rspRdata=0, rspError=0, reqReady=0; reqReady=1 one cycle after release.
- Full-word store/load: store addr 0 size 3 data 64'h0123456789abcdef, then load addr 0 size 3 → rspValid on the following cycle, rspRdata=64'h0123456789abcdef, rspError=0.
- Sub-word load: load addr 1 size 0 → rspRdata=64'hcd; load addr 2 size 1 → 64'h89ab.
- Split (macro defined): store addr 6 size 3 data 64'h1122334455667788 → reqReady=0 for one cycle, rspValid two cycles after acceptance; load addr 8 size 1 → 64'h5566; load addr 6 size 3 → 64'h1122334455667788.
- Split (macro undefined): same store → rspError=1 after one cycle; load addr 8 size 3 returns the prior contents.
- Range fault: load addr 124 size 3 → rspError=1, rspRdata=0; store addr 128 size 0 → rspError=1, memory unchanged.
- Reset mid-split: assert resetN=0 during SPLIT → no rspValid; word 0 bytes 6..7 updated, word 1 untouched.
